// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 4-bit adder among NREQ requesters,
// with valid/ready on both sides. Optional op counter: ADD_ARB_STATS_EN.

module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] c
);
  assign c = {1'b0, a} + {1'b0, b};
endmodule

module add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [4:0]        res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [15:0]       op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_next;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [3:0]     sel_a;
  logic [3:0]     sel_b;
  logic [3:0]     op_a;
  logic [3:0]     op_b;
  logic [IDW-1:0] op_id;
  logic [4:0]     sum;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NREQ;
      cand = idx[IDW-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[4*i +: 4];
        sel_b = req_b[4*i +: 4];
      end
    end
  end

  assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Grant is withheld during reset so nothing is accepted and then discarded.
  assign req_ready = (state == IDLE && !rst && grant_found)
                     ? (NREQ'(1) << grant_idx) : '0;

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  add4 u_add (
    .a (op_a),
    .b (op_b),
    .c (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= grant_idx;
            rr_ptr <= ptr_next;
          end
        end
        EXEC: begin
          res_data  <= sum;
          res_id    <= op_id;
          res_valid <= 1'b1;
        end
        RESP: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ADD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                         op_count <= '0;
    else if (res_valid && res_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter (NREQ=4); checks op_count
// as well when ADD_ARB_STATS_EN is defined.

module tb_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [4:0]        res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;
`ifdef ADD_ARB_STATS_EN
  logic [15:0]       op_count;
`endif

  int checks = 0;
  int errors = 0;

  add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
`ifdef ADD_ARB_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] a,
                               input logic [15:0] b, input logic rr);
    req_valid = valid;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full op from a lone requester, consumer always ready.
  task automatic runOp(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] exp_sum, input string tag);
    logic [15:0] av;
    logic [15:0] bv;
    av = '0;
    bv = '0;
    av[4*idx +: 4] = a;
    bv[4*idx +: 4] = b;
    applyStimulus(4'(1 << idx), av, bv, 1'b1);
    #1;
    checkOutput({tag, " grant"}, 32'(req_ready), 32'(1 << idx));
    tick;
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
    checkOutput({tag, " exec busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " exec valid"}, 32'(res_valid), 32'd0);
    tick;
    checkOutput({tag, " resp valid"}, 32'(res_valid), 32'd1);
    checkOutput({tag, " resp data"}, 32'(res_data), 32'(exp_sum));
    checkOutput({tag, " resp id"}, 32'(res_id), 32'(idx));
    tick;
    checkOutput({tag, " idle valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic pulseReset;
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  logic [4:0] rr_sums [4];

  initial begin
    rr_sums[0] = 5'd6;
    rr_sums[1] = 5'd9;
    rr_sums[2] = 5'd12;
    rr_sums[3] = 5'd15;

    // Reset with all requests pending: nothing may be granted.
    rst = 1'b1;
    applyStimulus(4'b1111, 16'h4321, 16'hB975, 1'b0);
    tick;
    tick;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset res_data", 32'(res_data), 32'd0);
    checkOutput("reset res_id", 32'(res_id), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
    tick;

    $display("[TB] single request 9+7 on requester 2");
    runOp(2, 4'd9, 4'd7, 5'd16, "t1");

    $display("[TB] round-robin with all requesters valid");
    pulseReset();
    applyStimulus(4'b1111, 16'h4321, 16'hB975, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("rr grant %0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick;
      checkOutput($sformatf("rr exec ready %0d", k), 32'(req_ready), 32'd0);
      tick;
      checkOutput($sformatf("rr resp ready %0d", k), 32'(req_ready), 32'd0);
      checkOutput($sformatf("rr id %0d", k), 32'(res_id), 32'(k % 4));
      checkOutput($sformatf("rr data %0d", k), 32'(res_data), 32'(rr_sums[k % 4]));
      tick;
    end
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);

    $display("[TB] back-pressure in RESP");
    applyStimulus(4'b0010, 16'h0030, 16'h0040, 1'b0);
    #1;
    checkOutput("bp grant", 32'(req_ready), 32'b0010);
    tick;
    applyStimulus(4'b0001, 16'h0005, 16'h0006, 1'b0);
    tick;
    checkOutput("bp resp valid", 32'(res_valid), 32'd1);
    checkOutput("bp resp data", 32'(res_data), 32'd7);
    for (int k = 0; k < 5; k++) begin
      tick;
      checkOutput($sformatf("bp hold valid %0d", k), 32'(res_valid), 32'd1);
      checkOutput($sformatf("bp hold data %0d", k), 32'(res_data), 32'd7);
      checkOutput($sformatf("bp hold id %0d", k), 32'(res_id), 32'd1);
      checkOutput($sformatf("bp hold ready %0d", k), 32'(req_ready), 32'd0);
      checkOutput($sformatf("bp hold busy %0d", k), 32'(busy), 32'd1);
    end
    res_ready = 1'b1;
    tick;
    checkOutput("bp release valid", 32'(res_valid), 32'd0);
    checkOutput("bp release busy", 32'(busy), 32'd0);
    checkOutput("bp next grant", 32'(req_ready), 32'b0001);
    tick;
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
    tick;
    checkOutput("bp second data", 32'(res_data), 32'd11);
    checkOutput("bp second id", 32'(res_id), 32'd0);
    tick;

    $display("[TB] operand width boundaries");
    runOp(3, 4'd15, 4'd15, 5'b11110, "max");
    runOp(0, 4'd0, 4'd0, 5'd0, "zero");
    runOp(1, 4'd8, 4'd8, 5'd16, "carry");

    $display("[TB] reset during EXEC");
    applyStimulus(4'b0100, 16'h0500, 16'h0600, 1'b1);
    #1;
    checkOutput("mid grant", 32'(req_ready), 32'b0100);
    tick;
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
    checkOutput("mid exec busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("mid rst valid", 32'(res_valid), 32'd0);
    checkOutput("mid rst busy", 32'(busy), 32'd0);
    checkOutput("mid rst data", 32'(res_data), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      checkOutput($sformatf("mid no stale %0d", k), 32'(res_valid), 32'd0);
    end
    applyStimulus(4'b1111, 16'h4321, 16'hB975, 1'b1);
    #1;
    checkOutput("mid ptr cleared", 32'(req_ready), 32'b0001);
    tick;
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1);
    tick;
    checkOutput("mid after id", 32'(res_id), 32'd0);
    checkOutput("mid after data", 32'(res_data), 32'd6);
    tick;

`ifdef ADD_ARB_STATS_EN
    $display("[TB] op counter");
    pulseReset();
    checkOutput("cnt reset", 32'(op_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      runOp(i % 4, 4'(i), 4'd1, 5'(i + 1), $sformatf("cnt op%0d", i));
    end
    checkOutput("cnt ten", 32'(op_count), 32'd10);
    applyStimulus(4'b0001, 16'h0002, 16'h0003, 1'b0);
    tick;
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b0);
    tick;
    checkOutput("cnt bp resp", 32'(op_count), 32'd10);
    tick;
    checkOutput("cnt bp hold", 32'(op_count), 32'd10);
    res_ready = 1'b1;
    tick;
    checkOutput("cnt accepted", 32'(op_count), 32'd11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
